seg7_scan_decoder: RTL and testbench

- Reader-side counterpart to the BCD-to-7-segment driver path: samples multiplexed common-anode segment and anode lines and reconstructs the four displayed BCD digits.
- Used for loopback self-check of the display driver on board and as a bench monitor.
- Accepts a digit only after its pattern has been stable for a programmable number of clocks.
- Publishes a complete 4-digit frame atomically once every digit position has been seen.

---
 rtl/seg7_scan_if.sv | 21 ++
 rtl/seg7_scan_decoder.sv | 149 ++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_if.sv
// Display-side bus of the 7-segment scan decoder: sampled segment/anode lines
// plus the reconstructed frame outputs.
interface seg7_scan_if;
  logic [6:0]  seg_in;
  logic [3:0]  an_in;
  logic [15:0] digits_out;
  logic [3:0]  digit_err;
  logic        frame_valid;
  logic        blank;
  logic        timeout;

  modport master (
    output seg_in, an_in,
    input  digits_out, digit_err, frame_valid, blank, timeout
  );

  modport slave (
    input  seg_in, an_in,
    output digits_out, digit_err, frame_valid, blank, timeout
  );
endinterface

// File: rtl/seg7_scan_decoder.sv
// Reconstructs four BCD digits from multiplexed active-low segment/anode lines,
// with stability filtering, atomic frame commit and a sticky frame timeout.
module seg7_scan_decoder #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned FRAME_TIMEOUT = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  seg7_scan_if.slave  bus
);

  localparam int unsigned SCW = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned TOW = $clog2(FRAME_TIMEOUT + 1);

  logic [10:0]    sync1, sync2, prev;
  logic [SCW-1:0] stab_cnt;
  logic [3:0]     seen, seen_n;
  logic [15:0]    shadow, shadow_n;
  logic [3:0]     shadow_err, shadow_err_n;
  logic [TOW-1:0] to_cnt;
  logic [15:0]    digits_q;
  logic [3:0]     err_q;
  logic           fv_q, blank_q, timeout_q;

  logic [3:0] an_s;
  logic [6:0] seg_s;
  logic       same, capture, commit, slot_valid;
  logic [1:0] slot;
  logic [3:0] dec_digit;
  logic       dec_err;

  assign an_s  = sync2[10:7];
  assign seg_s = sync2[6:0];
  assign same  = (sync2 == prev);
  // Capture only on the transition into saturation: one capture per stable run.
  assign capture = same && (stab_cnt == SCW'(STABLE_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '1;
      sync2 <= '1;
      prev  <= '1;
    end else begin
      sync1 <= {bus.an_in, bus.seg_in};
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stab_cnt <= '0;
    end else if (!same) begin
      stab_cnt <= SCW'(1);
    end else if (stab_cnt != SCW'(STABLE_CYCLES)) begin
      stab_cnt <= stab_cnt + 1'b1;
    end
  end

  always_comb begin
    dec_digit = 4'hE;
    dec_err   = 1'b0;
    case (seg_s)
      7'h40:   dec_digit = 4'd0;
      7'h79:   dec_digit = 4'd1;
      7'h24:   dec_digit = 4'd2;
      7'h30:   dec_digit = 4'd3;
      7'h19:   dec_digit = 4'd4;
      7'h12:   dec_digit = 4'd5;
      7'h02:   dec_digit = 4'd6;
      7'h78:   dec_digit = 4'd7;
      7'h00:   dec_digit = 4'd8;
      7'h10:   dec_digit = 4'd9;
      7'h7F:   dec_digit = 4'hF;
      default: dec_err   = 1'b1;
    endcase
  end

  always_comb begin
    slot       = '0;
    slot_valid = 1'b1;
    case (an_s)
      4'b1110: slot = 2'd0;
      4'b1101: slot = 2'd1;
      4'b1011: slot = 2'd2;
      4'b0111: slot = 2'd3;
      default: slot_valid = 1'b0;
    endcase
  end

  always_comb begin
    shadow_n     = shadow;
    shadow_err_n = shadow_err;
    seen_n       = seen;
    commit       = 1'b0;
    if (capture && slot_valid) begin
      shadow_n[{slot, 2'b00} +: 4] = dec_digit;
      shadow_err_n[slot]           = dec_err;
      seen_n[slot]                 = 1'b1;
      if (seen_n == 4'hF) begin
        commit = 1'b1;
        seen_n = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen       <= '0;
      shadow     <= '1;
      shadow_err <= '0;
      digits_q   <= '1;
      err_q      <= '0;
      fv_q       <= 1'b0;
      blank_q    <= 1'b1;
    end else begin
      seen       <= seen_n;
      shadow     <= shadow_n;
      shadow_err <= shadow_err_n;
      fv_q       <= commit;
      blank_q    <= &an_s;
      if (commit) begin
        digits_q <= shadow_n;
        err_q    <= shadow_err_n;
      end
    end
  end

  // Commit takes priority over expiry on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt    <= '0;
      timeout_q <= 1'b0;
    end else if (commit) begin
      to_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (to_cnt != TOW'(FRAME_TIMEOUT)) to_cnt <= to_cnt + 1'b1;
      if (to_cnt >= TOW'(FRAME_TIMEOUT - 1)) timeout_q <= 1'b1;
    end
  end

  assign bus.digits_out  = digits_q;
  assign bus.digit_err   = err_q;
  assign bus.frame_valid = fv_q;
  assign bus.blank       = blank_q;
  assign bus.timeout     = timeout_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: directed scenarios plus random scanning, checked
// every cycle against a sample-history reference model.
module tb_seg7_scan_decoder;
  localparam int S  = 4;
  localparam int FT = 50;
  localparam int H  = S + 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg7_scan_if bus ();

  seg7_scan_decoder #(.STABLE_CYCLES(S), .FRAME_TIMEOUT(FT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int fv_count = 0;
  int first_fv = 0;
  logic fv_timeout = 1'b0;

  // Reference model: hist[i] is the pin value sampled i edges ago.
  logic [10:0] hist [H];
  logic [3:0]  m_sh [4];
  logic        m_er [4];
  logic        m_seen [4];
  logic [15:0] exp_digits;
  logic [3:0]  exp_err;
  logic        exp_fv, exp_blank, exp_timeout;
  int          since;

  logic [6:0] pat [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                           7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic lookup(input logic [6:0] s, output logic [3:0] d, output logic e);
    d = 4'hE;
    e = 1'b1;
    if (s == 7'h7F) begin
      d = 4'hF;
      e = 1'b0;
    end
    for (int i = 0; i < 10; i++)
      if (pat[i] == s) begin
        d = 4'(i);
        e = 1'b0;
      end
  endtask

  task automatic model_step();
    logic [10:0] v;
    logic        cap, all_seen, e;
    logic [3:0]  d;
    int          k;
    if (!rst_n) begin
      for (int i = 0; i < H; i++) hist[i] = '1;
      for (int i = 0; i < 4; i++) begin
        m_sh[i] = 4'hF; m_er[i] = 1'b0; m_seen[i] = 1'b0;
      end
      exp_digits = 16'hFFFF; exp_err = 4'h0; exp_fv = 1'b0;
      exp_blank = 1'b1; exp_timeout = 1'b0; since = 0;
    end else begin
      for (int i = H - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = {bus.an_in, bus.seg_in};
      v = hist[2];
      // A capture needs exactly S equal samples ending at v (preceded by a different one).
      cap = 1'b1;
      for (int i = 3; i <= S + 1; i++) if (hist[i] != v) cap = 1'b0;
      if (hist[S+2] == v) cap = 1'b0;
      exp_fv = 1'b0;
      if (since < FT) since++;
      k = -1;
      for (int i = 0; i < 4; i++) if (v[7+i] == 1'b0) k = (k == -1) ? i : -2;
      if (cap && k >= 0) begin
        lookup(v[6:0], d, e);
        m_sh[k] = d; m_er[k] = e; m_seen[k] = 1'b1;
        all_seen = m_seen[0] & m_seen[1] & m_seen[2] & m_seen[3];
        if (all_seen) begin
          for (int j = 0; j < 4; j++) begin
            exp_digits[4*j +: 4] = m_sh[j];
            exp_err[j] = m_er[j];
            m_seen[j] = 1'b0;
          end
          exp_fv = 1'b1;
          since = 0;
        end
      end
      exp_timeout = (since >= FT);
      exp_blank = (v[10:7] == 4'hF);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    cyc++;
    model_step();
    chk("digits_out", 32'(bus.digits_out), 32'(exp_digits));
    chk("digit_err", 32'(bus.digit_err), 32'(exp_err));
    chk("frame_valid", 32'(bus.frame_valid), 32'(exp_fv));
    chk("blank", 32'(bus.blank), 32'(exp_blank));
    chk("timeout", 32'(bus.timeout), 32'(exp_timeout));
    if (bus.frame_valid === 1'b1) begin
      fv_count++;
      fv_timeout = bus.timeout;
    end
  endtask

  task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
    bus.an_in  = a;
    bus.seg_in = s;
    first_fv = 0;
    for (int i = 1; i <= n; i++) begin
      cycle();
      if (bus.frame_valid === 1'b1 && first_fv == 0) first_fv = i;
    end
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    for (int i = 0; i < n; i++) begin
      bus.an_in  = 4'($urandom);
      bus.seg_in = 7'($urandom);
      cycle();
    end
    bus.an_in  = 4'hF;
    bus.seg_in = 7'h7F;
    rst_n = 1'b1;
  endtask

  task automatic scan4(input logic [6:0] s0, input logic [6:0] s1,
                       input logic [6:0] s2, input logic [6:0] s3);
    hold(4'b1110, s0, 8);
    hold(4'b1101, s1, 8);
    hold(4'b1011, s2, 8);
    hold(4'b0111, s3, 8);
  endtask

  initial begin
    int f0;
    logic [3:0] a;
    logic [6:0] s;
    bus.an_in  = 4'hF;
    bus.seg_in = 7'h7F;

    // Reset state with random pins
    do_reset(4);
    chk("reset_digits", 32'(bus.digits_out), 32'h0000FFFF);
    chk("reset_blank", 32'(bus.blank), 32'h1);
    f0 = fv_count;
    hold(4'hF, 7'h7F, 10);
    chk("idle_no_frame", 32'(fv_count - f0), 32'd0);

    // Clean scan: commit 5 edges after the 4th change (6th sample after it)
    do_reset(2);
    hold(4'hF, 7'h7F, 3);
    f0 = fv_count;
    hold(4'b1110, 7'h40, 8);
    hold(4'b1101, 7'h79, 8);
    hold(4'b1011, 7'h30, 8);
    hold(4'b0111, 7'h12, 8);
    chk("clean_fv_latency", 32'(first_fv), 32'd6);
    chk("clean_digits", 32'(bus.digits_out), 32'h5310);
    chk("clean_err", 32'(bus.digit_err), 32'h0);
    chk("clean_frames", 32'(fv_count - f0), 32'd1);

    // Glitch shorter than the stability window is ignored
    do_reset(2);
    f0 = fv_count;
    hold(4'b1110, 7'h40, 8);
    hold(4'b1101, 7'h79, 3);
    hold(4'b1101, 7'h00, 2);
    hold(4'b1101, 7'h79, 6);
    hold(4'b1011, 7'h30, 8);
    hold(4'b0111, 7'h12, 8);
    chk("glitch_digits", 32'(bus.digits_out), 32'h5310);
    chk("glitch_frames", 32'(fv_count - f0), 32'd1);

    // Blank and invalid patterns
    do_reset(2);
    scan4(7'h40, 7'h79, 7'h7F, 7'h55);
    chk("invalid_digits", 32'(bus.digits_out), 32'hEF10);
    chk("invalid_err", 32'(bus.digit_err), 32'h8);

    // Overwrite (latest wins) and multi-anode rejection
    do_reset(2);
    f0 = fv_count;
    hold(4'b1110, 7'h24, 8);
    hold(4'b1110, 7'h78, 8);
    hold(4'b1100, 7'h40, 10);
    hold(4'b1101, 7'h79, 8);
    hold(4'b1011, 7'h30, 8);
    hold(4'b0111, 7'h12, 8);
    chk("overwrite_digits", 32'(bus.digits_out), 32'h5317);
    chk("overwrite_frames", 32'(fv_count - f0), 32'd1);

    // Timeout rises on edge FT after reset, is sticky, and clears on commit
    do_reset(2);
    hold(4'hF, 7'h7F, FT - 1);
    chk("timeout_before", 32'(bus.timeout), 32'h0);
    hold(4'hF, 7'h7F, 1);
    chk("timeout_at_ft", 32'(bus.timeout), 32'h1);
    hold(4'hF, 7'h7F, 20);
    chk("timeout_sticky", 32'(bus.timeout), 32'h1);
    fv_timeout = 1'b1;
    scan4(7'h19, 7'h02, 7'h78, 7'h10);
    chk("timeout_on_commit", 32'(fv_timeout), 32'h0);
    chk("timeout_digits", 32'(bus.digits_out), 32'h9764);

    // Reset mid-frame discards partial state
    hold(4'b1110, 7'h24, 8);
    hold(4'b1101, 7'h24, 8);
    do_reset(2);
    f0 = fv_count;
    hold(4'b1011, 7'h24, 8);
    hold(4'b0111, 7'h24, 8);
    hold(4'hF, 7'h7F, 4);
    chk("midreset_no_frame", 32'(fv_count - f0), 32'd0);
    scan4(7'h24, 7'h24, 7'h24, 7'h24);
    chk("midreset_frames", 32'(fv_count - f0), 32'd1);
    chk("midreset_digits", 32'(bus.digits_out), 32'h2222);

    // Random scanning
    for (int t = 0; t < 400; t++) begin
      case ($urandom_range(0, 9))
        0:       a = 4'hF;
        1:       a = 4'($urandom);
        default: begin
          a = 4'hF;
          a[$urandom_range(0, 3)] = 1'b0;
        end
      endcase
      case ($urandom_range(0, 9))
        0:       s = 7'h7F;
        1:       s = 7'($urandom);
        default: s = pat[$urandom_range(0, 9)];
      endcase
      if ($urandom_range(0, 79) == 0) do_reset(2);
      hold(a, s, $urandom_range(1, 10));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
